mixer_tune_controller: RTL and testbench
========================================

# mixer_tune_controller

Sequences retuning of the NCO that drives the I/Q mixer. It accepts a new phase-increment (tuning word) over a valid/ready handshake and mutes the mixer output gate while the mixer pipeline drains. It then loads the word into the NCO, optionally clears the NCO phase, and holds the gate closed until the downstream decimation path has flushed. It sits between the control/UART register interface and the NCO + mixer datapath.

## Interface
Parameters:
- PHASE_WIDTH, 32, NCO phase-increment width
- DRAIN_CYCLES, 4, cycles muted before load; covers mixer rf_in delay + output register; legal range 1..255
- FLUSH_CYCLES, 64, cycles muted after load; covers CIC/filter settle; legal range 1..65535
- RESET_WORD, 32'h0, phase increment driven from reset

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- tune_valid  in  1  request present
- tune_ready  out  1  controller can accept a request
- tune_word  in  PHASE_WIDTH  requested phase increment
- tune_phase_clear  in  1  request flag: clear NCO phase at load
- nco_phase_inc  out  PHASE_WIDTH  registered increment to NCO
- nco_phase_clear  out  1  one-cycle pulse to NCO phase accumulator
- mix_enable  out  1  mixer output gate; 0 forces I/Q to zero downstream
- busy  out  1  high in any state other than IDLE
- tune_done  out  1  one-cycle pulse when a retune completes
- retune_count  out  16  completed retunes since reset; wraps 16'hFFFF -> 0

## Operation
- FSM states: STARTUP, IDLE, DRAIN, LOAD, FLUSH, DONE.
- STARTUP (reset state): counter loads FLUSH_CYCLES-1 and decrements. At 0, go to DONE without asserting tune_done or incrementing retune_count; this is startup only. Then go to IDLE.
- IDLE: tune_ready=1. On tune_valid&&tune_ready, latch tune_word and tune_phase_clear, load counter with DRAIN_CYCLES-1, and go to DRAIN.
- DRAIN: mix_enable=0. Decrement the counter; at 0, go to LOAD.
- LOAD: exactly 1 cycle. nco_phase_inc <= latched word. nco_phase_clear=1 in this cycle if the latched flag is set. Counter loads FLUSH_CYCLES-1. Go to FLUSH.
- FLUSH: mix_enable=0. Decrement; at 0, go to DONE.
- DONE: exactly 1 cycle. tune_done=1 and retune_count++ (post-reset retunes only). Go to IDLE.
- mix_enable is registered. It is 1 only in IDLE.
- tune_ready is 0 in every state except IDLE. Requests presented while busy are held off, not dropped. The requester must hold tune_valid and tune_word stable until accepted.
- tune_word is sampled only at acceptance. Later changes have no effect on the load.
- Counter width is 16 bits. Decrement with no underflow: the transition fires at 0.

## Timing
- Reset values: tune_ready=0, nco_phase_inc=RESET_WORD, nco_phase_clear=0, mix_enable=0, busy=1, tune_done=0, retune_count=0, state=STARTUP.
- First tune_ready=1 is FLUSH_CYCLES+1 cycles after rst deasserts.
- Accept at cycle T:
  - mix_enable falls at T+1.
  - DRAIN occupies T+1..T+DRAIN_CYCLES.
  - LOAD is at T+DRAIN_CYCLES+1. New nco_phase_inc is visible at T+DRAIN_CYCLES+2.
  - FLUSH lasts FLUSH_CYCLES cycles.
  - tune_done is at T+DRAIN_CYCLES+FLUSH_CYCLES+2.
  - mix_enable=1 and tune_ready=1 at T+DRAIN_CYCLES+FLUSH_CYCLES+3.
- Back-to-back: a request held valid through DONE is accepted in the first IDLE cycle. Minimum period per retune is DRAIN_CYCLES+FLUSH_CYCLES+3.
- rst asserted mid-retune: all outputs take reset values immediately. The in-flight request is discarded with no tune_done. nco_phase_inc returns to RESET_WORD.

## Structure
- Shared package sdr_pkg:
  - FSM state encoding (localparam constants: ST_STARTUP..ST_DONE)
  - COUNT_WIDTH=16 and default PHASE_WIDTH
- One natural sub-module: settle_counter. It is a loadable 16-bit down-counter with a zero flag, reused for the DRAIN, FLUSH and STARTUP waits. Everything else stays in mixer_tune_controller.

## Test plan
- Reset/startup: RESET_WORD=32'h1234, FLUSH_CYCLES=8, rst released at cycle 0.
  - mix_enable=0 and tune_ready=0 through cycle 8; both rise at cycle 9.
  - nco_phase_inc=32'h1234 throughout; no tune_done; retune_count=0.
- Single retune: DRAIN=4, FLUSH=8, word 32'h0A3D70A4 with phase_clear=1 accepted at T.
  - nco_phase_clear pulses at T+5.
  - nco_phase_inc=32'h0A3D70A4 from T+6.
  - tune_done at T+14; mix_enable and tune_ready rise at T+15; retune_count=1.
- Back-pressure: a second request is asserted at T+3 and held.
  - It is not accepted until T+15.
  - tune_word changed from 32'h1 to 32'h2 at T+10 (before acceptance) loads 32'h2.
  - retune_count=2 after the second tune_done.
- phase_clear=0 request: nco_phase_clear never pulses; the word still loads at LOAD.
- Reset mid-FLUSH: rst at T+9 for 1 cycle.
  - Outputs return to reset values asynchronously.
  - No tune_done; retune_count=0; the startup sequence repeats.
- Counter wrap: force retune_count=16'hFFFF, complete one retune → 16'h0000.

Source files
------------

// File: rtl/sdr_pkg.sv
// Shared definitions for the SDR tuning path: controller state encoding and
// common widths.
package sdr_pkg;

  localparam int COUNT_WIDTH = 16;
  localparam int PHASE_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_LOAD    = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
// Shared by the startup, drain and flush waits.
module settle_counter
  import sdr_pkg::*;
#(
  parameter logic [COUNT_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_val,
  input  logic                   dec_en,
  output logic                   zero
);

  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec_en && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= RESET_VAL;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mixer_tune_controller.sv
// Retune sequencer for the mixer NCO: mute, drain, load the new increment,
// flush the decimation path, then reopen the output gate.
module mixer_tune_controller
  import sdr_pkg::*;
#(
  parameter int                     PHASE_WIDTH  = sdr_pkg::PHASE_WIDTH,
  parameter int                     DRAIN_CYCLES = 4,
  parameter int                     FLUSH_CYCLES = 64,
  parameter logic [PHASE_WIDTH-1:0] RESET_WORD   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tune_valid,
  output logic                   tune_ready,
  input  logic [PHASE_WIDTH-1:0] tune_word,
  input  logic                   tune_phase_clear,
  output logic [PHASE_WIDTH-1:0] nco_phase_inc,
  output logic                   nco_phase_clear,
  output logic                   mix_enable,
  output logic                   busy,
  output logic                   tune_done,
  output logic [15:0]            retune_count
);

  localparam logic [COUNT_WIDTH-1:0] DRAIN_LD = COUNT_WIDTH'(DRAIN_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] FLUSH_LD = COUNT_WIDTH'(FLUSH_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] word_q, word_d;
  logic [PHASE_WIDTH-1:0] inc_q, inc_d;
  logic                   flag_q, flag_d;
  logic                   clear_q, clear_d;
  logic                   gate_q, gate_d;
  logic                   done_q, done_d;
  logic [15:0]            count_q, count_d;

  logic                   cnt_load;
  logic [COUNT_WIDTH-1:0] cnt_val;
  logic                   cnt_dec;
  logic                   cnt_zero;

  settle_counter #(.RESET_VAL(FLUSH_LD)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec_en   (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    flag_d   = flag_q;
    inc_d    = inc_q;
    count_d  = count_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = DRAIN_LD;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_STARTUP: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = ST_DONE;
      end
      ST_IDLE: begin
        if (tune_valid && gate_q) begin
          word_d   = tune_word;
          flag_d   = tune_phase_clear;
          cnt_load = 1'b1;
          cnt_val  = DRAIN_LD;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        inc_d    = word_q;
        cnt_load = 1'b1;
        cnt_val  = FLUSH_LD;
        state_d  = ST_FLUSH;
      end
      ST_FLUSH: begin
        cnt_dec = 1'b1;
        // Only a real retune reaches DONE through FLUSH; the startup pass skips the pulse.
        if (cnt_zero) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          count_d = count_q + 16'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_STARTUP;
    endcase
    // Outputs registered from the next state so they line up with the state they describe.
    gate_d  = (state_d == ST_IDLE);
    clear_d = (state_d == ST_LOAD) && flag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STARTUP;
      word_q  <= RESET_WORD;
      flag_q  <= 1'b0;
      inc_q   <= RESET_WORD;
      clear_q <= 1'b0;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      flag_q  <= flag_d;
      inc_q   <= inc_d;
      clear_q <= clear_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign tune_ready      = gate_q;
  assign mix_enable      = gate_q;
  assign nco_phase_inc   = inc_q;
  assign nco_phase_clear = clear_q;
  assign tune_done       = done_q;
  assign retune_count    = count_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mixer_tune_controller.sv
// Directed bench for mixer_tune_controller with DRAIN=4, FLUSH=8, RESET_WORD=32'h1234.
module tb_mixer_tune_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tune_valid = 1'b0;
  logic        tune_ready;
  logic [31:0] tune_word = '0;
  logic        tune_phase_clear = 1'b0;
  logic [31:0] nco_phase_inc;
  logic        nco_phase_clear;
  logic        mix_enable;
  logic        busy;
  logic        tune_done;
  logic [15:0] retune_count;

  int vectors = 0;
  int errors  = 0;

  localparam logic [31:0] RW = 32'h1234;
  localparam logic [31:0] W1 = 32'h0A3D70A4;

  mixer_tune_controller #(
    .PHASE_WIDTH(32), .DRAIN_CYCLES(4), .FLUSH_CYCLES(8), .RESET_WORD(RW)
  ) dut (
    .clk(clk), .rst(rst),
    .tune_valid(tune_valid), .tune_ready(tune_ready),
    .tune_word(tune_word), .tune_phase_clear(tune_phase_clear),
    .nco_phase_inc(nco_phase_inc), .nco_phase_clear(nco_phase_clear),
    .mix_enable(mix_enable), .busy(busy), .tune_done(tune_done),
    .retune_count(retune_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset values, checked while rst is still high.
  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(tune_ready), 32'd0);
    chk({tag, "_inc"},   nco_phase_inc, RW);
    chk({tag, "_clr"},   32'(nco_phase_clear), 32'd0);
    chk({tag, "_mix"},   32'(mix_enable), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd1);
    chk({tag, "_done"},  32'(tune_done), 32'd0);
    chk({tag, "_cnt"},   32'(retune_count), 32'd0);
  endtask

  // Release reset at a falling edge (that cycle is cycle 0), walk startup to cycle 9.
  task automatic startup(input string tag);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      #1;
      chk({tag, "_ready_lo"}, 32'(tune_ready), 32'd0);
      chk({tag, "_mix_lo"},   32'(mix_enable), 32'd0);
      chk({tag, "_nodone"},   32'(tune_done), 32'd0);
      chk({tag, "_inc"},      nco_phase_inc, RW);
      @(negedge clk);
    end
    #1;
    chk({tag, "_ready_c9"}, 32'(tune_ready), 32'd1);
    chk({tag, "_mix_c9"},   32'(mix_enable), 32'd1);
    chk({tag, "_busy_c9"},  32'(busy), 32'd0);
    chk({tag, "_cnt"},      32'(retune_count), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    startup("start");
    @(posedge clk); #1;

    // Retune 1 at T, second request arrives at T+3 and is held off.
    tune_valid = 1'b1; tune_word = W1; tune_phase_clear = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) tune_valid = 1'b0;
      chk("r1_clr",   32'(nco_phase_clear), 32'(k == 5));
      chk("r1_inc",   nco_phase_inc, (k >= 6) ? W1 : RW);
      chk("r1_done",  32'(tune_done), 32'(k == 14));
      chk("r1_ready", 32'(tune_ready), 32'(k == 15));
      chk("r1_mix",   32'(mix_enable), 32'(k == 15));
      chk("r1_busy",  32'(busy), 32'(k != 15));
      if (k == 3) begin
        tune_valid = 1'b1; tune_word = 32'h1; tune_phase_clear = 1'b0;
      end
      if (k == 10) tune_word = 32'h2;
    end
    chk("r1_count", 32'(retune_count), 32'd1);

    // Retune 2 is accepted now (T+15) with phase_clear=0 and word 2.
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) begin
        tune_valid = 1'b0; tune_word = 32'h7;
      end
      chk("r2_clr",   32'(nco_phase_clear), 32'd0);
      chk("r2_inc",   nco_phase_inc, (k >= 6) ? 32'h2 : W1);
      chk("r2_done",  32'(tune_done), 32'(k == 14));
      chk("r2_ready", 32'(tune_ready), 32'(k == 15));
    end
    chk("r2_count", 32'(retune_count), 32'd2);

    // Retune 3 is interrupted by reset in FLUSH at T+9.
    tune_valid = 1'b1; tune_word = 32'h55; tune_phase_clear = 1'b1;
    tick();
    tune_valid = 1'b0;
    repeat (8) tick();
    chk("r3_inc_loaded", nco_phase_inc, 32'h55);
    #3;
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    @(posedge clk); #1;
    chk_reset("midrst_hold");
    startup("restart");

    // Counter wrap from 16'hFFFF to 0.
    force dut.count_q = 16'hFFFF;
    tick();
    release dut.count_q;
    tick();
    chk("wrap_pre", 32'(retune_count), 32'h0000FFFF);
    tune_valid = 1'b1; tune_word = 32'h9; tune_phase_clear = 1'b0;
    tick();
    tune_valid = 1'b0;
    repeat (13) tick();
    chk("wrap_done", 32'(tune_done), 32'd1);
    chk("wrap_cnt",  32'(retune_count), 32'd0);
    chk("wrap_inc",  nco_phase_inc, 32'h9);
    tick();
    chk("wrap_ready", 32'(tune_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
